// File: rtl/picoblaze_in_port.sv
// picoblaze_in_port: read-side register file for the KCPSM3 in_port.
// Publishes debounced buttons, game-over status, score, sticky read-clear
// event flags and a saturating tick counter at four consecutive port IDs.
// Optional macro PICO_IN_IRQ_EN: drives interrupt from a pending flag set by
// any event and cleared by interrupt_ack; without it interrupt is tied low.

// Per-button lane: 2-FF synchroniser followed by a stability counter.
module picoblaze_in_port_db #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d, s2_q, s2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differ, hit;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    differ   = (s2_q != stable_q);
    hit      = differ && (cnt_q == CNT_MAX);
    cnt_d    = (differ && !hit) ? cnt_q + 1'b1 : '0;
    stable_d = hit ? s2_q : stable_q;
    rise     = hit && s2_q;
  end

  // Synchroniser, counter and accepted level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
endmodule

module picoblaze_in_port #(
  parameter logic [7:0]  BASE_PORT_ID    = 8'h10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] in_port,
  input  logic [1:0] btn_raw,
  input  logic       game_over,
  input  logic [7:0] score,
  input  logic       level_tick,
  output logic       interrupt,
  input  logic       interrupt_ack
);
  localparam int unsigned NUM_BTN = 2;
  localparam logic [7:0] R_STATUS = BASE_PORT_ID;
  localparam logic [7:0] R_EVENTS = BASE_PORT_ID + 8'd1;
  localparam logic [7:0] R_SCORE  = BASE_PORT_ID + 8'd2;
  localparam logic [7:0] R_TICKS  = BASE_PORT_ID + 8'd3;

  logic [NUM_BTN-1:0] btn_stable, btn_rise;
  logic               go_s1_q, go_s1_d, go_s2_q, go_s2_d;
  logic [3:0]         sticky_q, sticky_d;
  logic [7:0]         ticks_q, ticks_d;
  logic [7:0]         in_port_q, in_port_d;
  logic [3:0]         ev;
  logic               rd_events, rd_ticks;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    picoblaze_in_port_db #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[i]),
      .stable(btn_stable[i]),
      .rise  (btn_rise[i])
    );
  end

  // Events, read-clear flags and the registered read mux. A read-clear and
  // an event on the same edge keep the event, so nothing is lost.
  always_comb begin
    go_s1_d   = game_over;
    go_s2_d   = go_s1_q;
    ev        = {level_tick, go_s1_q & ~go_s2_q, btn_rise};
    rd_events = read_strobe && (port_id == R_EVENTS);
    rd_ticks  = read_strobe && (port_id == R_TICKS);

    sticky_d = (rd_events ? 4'b0 : sticky_q) | ev;

    ticks_d = ticks_q;
    if (rd_ticks)
      ticks_d = {7'b0, level_tick};
    else if (level_tick && ticks_q != 8'hFF)
      ticks_d = ticks_q + 8'd1;

    case (port_id)
      R_STATUS: in_port_d = {5'b0, go_s2_q, btn_stable};
      R_EVENTS: in_port_d = {4'b0, sticky_q};
      R_SCORE:  in_port_d = score;
      R_TICKS:  in_port_d = ticks_q;
      default:  in_port_d = 8'h00;
    endcase
  end

  // Register state and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_s1_q   <= 1'b0;
      go_s2_q   <= 1'b0;
      sticky_q  <= 4'b0;
      ticks_q   <= 8'h00;
      in_port_q <= 8'h00;
    end else begin
      go_s1_q   <= go_s1_d;
      go_s2_q   <= go_s2_d;
      sticky_q  <= sticky_d;
      ticks_q   <= ticks_d;
      in_port_q <= in_port_d;
    end
  end

  assign in_port = in_port_q;

`ifdef PICO_IN_IRQ_EN
  logic irq_pend_q, irq_pend_d;

  // Pending request: a new event wins over a simultaneous acknowledge.
  always_comb begin
    irq_pend_d = (|ev) | (irq_pend_q & ~interrupt_ack);
  end

  // Interrupt request flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_pend_q <= 1'b0;
    else       irq_pend_q <= irq_pend_d;
  end

  assign interrupt = irq_pend_q;
`else
  // Polling build: firmware reads EVENTS instead of taking an interrupt.
  logic unused_irq_ack;
  assign unused_irq_ack = interrupt_ack;
  assign interrupt      = 1'b0;
`endif
endmodule

// File: tb/tb_picoblaze_in_port.sv
// Scoreboard bench for picoblaze_in_port (DEBOUNCE_CYCLES=16, base 8'h10).
// Reads push the model's expected byte; a monitor pops and compares in_port
// on the cycle after each read strobe. Interrupt checks follow the build.
module tb_picoblaze_in_port;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_id = 8'h00;
  logic       read_strobe = 1'b0;
  logic [7:0] in_port;
  logic [1:0] btn_raw = 2'b00;
  logic       game_over = 1'b0;
  logic [7:0] score = 8'h00;
  logic       level_tick = 1'b0;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;

  picoblaze_in_port #(
    .BASE_PORT_ID   (8'h10),
    .DEBOUNCE_CYCLES(16),
    .CNT_W          (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .read_strobe  (read_strobe),
    .in_port      (in_port),
    .btn_raw      (btn_raw),
    .game_over    (game_over),
    .score        (score),
    .level_tick   (level_tick),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: accepted levels, sticky flags, tick count, irq.
  logic [1:0] m_btn    = 2'b00;
  logic       m_go     = 1'b0;
  logic [3:0] m_sticky = 4'b0;
  int         m_ticks  = 0;
  logic       m_irq    = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] addr_q[$];
  logic       rs_q = 1'b0;
  logic [7:0] mon_e, mon_a;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h10:   return {5'b0, m_go, m_btn};
      8'h11:   return {4'b0, m_sticky};
      8'h12:   return score;
      8'h13:   return 8'(m_ticks);
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_tick();
    m_ticks     = (m_ticks >= 255) ? 255 : m_ticks + 1;
    m_sticky[3] = 1'b1;
    m_irq       = 1'b1;
  endtask

  function automatic logic [7:0] irq_exp();
`ifdef PICO_IN_IRQ_EN
    return {7'b0, m_irq};
`else
    return 8'h00;
`endif
  endfunction

  task automatic check_irq(input string nm);
    chk(nm, {7'b0, interrupt}, irq_exp());
  endtask

  // Issue a one-cycle read, optionally with a coincident level_tick.
  task automatic rd(input logic [7:0] a, input logic t);
    @(negedge clk);
    port_id     = a;
    read_strobe = 1'b1;
    level_tick  = t;
    exp_q.push_back(model_read(a));
    addr_q.push_back(a);
    if (a == 8'h11) m_sticky = 4'b0;
    if (a == 8'h13) m_ticks = 0;
    if (t) model_tick();
    @(negedge clk);
    read_strobe = 1'b0;
    level_tick  = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      level_tick = 1'b1;
      model_tick();
      @(negedge clk);
      level_tick = 1'b0;
    end
  endtask

  task automatic set_btn(input int i, input logic v);
    @(negedge clk);
    btn_raw[i] = v;
    repeat (24) @(negedge clk);
    if (v && !m_btn[i]) begin
      m_sticky[i] = 1'b1;
      m_irq       = 1'b1;
    end
    m_btn[i] = v;
  endtask

  task automatic set_go(input logic v);
    @(negedge clk);
    game_over = v;
    repeat (4) @(negedge clk);
    if (v && !m_go) begin
      m_sticky[2] = 1'b1;
      m_irq       = 1'b1;
    end
    m_go = v;
  endtask

  task automatic ack(input logic t, input string nm);
    @(negedge clk);
    interrupt_ack = 1'b1;
    level_tick    = t;
    m_irq         = 1'b0;
    if (t) model_tick();
    @(negedge clk);
    interrupt_ack = 1'b0;
    level_tick    = 1'b0;
    check_irq(nm);
  endtask

  // Monitor: in_port is valid the cycle after a read strobe is sampled.
  always @(posedge clk) rs_q <= read_strobe;

  always @(negedge clk) begin
    if (rs_q) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got %h, expected nothing", in_port);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = addr_q.pop_front();
        chk($sformatf("read_%h", mon_a), in_port, mon_e);
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_in_port", in_port, 8'h00);
    check_irq("reset_irq");
    reset = 1'b0;

    // Debounce timing: stable (and irq) rises 18 edges after the raw change
    @(negedge clk);
    btn_raw[0] = 1'b1;
    repeat (17) @(negedge clk);
    check_irq("irq_before_accept");
    @(negedge clk);
    m_btn[0] = 1'b1; m_sticky[0] = 1'b1; m_irq = 1'b1;
    check_irq("irq_on_accept");
    repeat (22) @(negedge clk);
    rd(8'h10, 1'b0);                      // 8'h01
    ack(1'b0, "irq_ack_clears");

    // 10-cycle glitch on btn1 is rejected
    @(negedge clk);
    btn_raw[1] = 1'b1;
    repeat (10) @(negedge clk);
    btn_raw[1] = 1'b0;
    repeat (30) @(negedge clk);
    rd(8'h10, 1'b0);                      // still 8'h01
    check_irq("glitch_no_irq");

    // Sticky flags and read-clear
    set_btn(1, 1'b1);
    set_go(1'b1);
    rd(8'h11, 1'b0);                      // 8'h07
    rd(8'h11, 1'b0);                      // 8'h00
    rd(8'h10, 1'b0);                      // 8'h07 status

    // Read-clear colliding with a level_tick
    rd(8'h11, 1'b1);                      // old value
    rd(8'h11, 1'b0);                      // 8'h08

    // Tick saturation and read-clear
    rd(8'h13, 1'b0);
    ticks(300);
    rd(8'h13, 1'b0);                      // 8'hFF
    rd(8'h13, 1'b0);                      // 8'h00
    ticks(3);
    rd(8'h13, 1'b0);                      // 8'h03
    rd(8'h13, 1'b1);                      // 8'h00 read, tick survives
    rd(8'h13, 1'b0);                      // 8'h01

    // Map decode and side-effect-free strobes
    score = 8'd42;
    rd(8'h12, 1'b0);
    rd(8'h14, 1'b0);
    rd(8'h00, 1'b0);
    rd(8'h10, 1'b0);
    rd(8'h12, 1'b0);
    rd(8'h11, 1'b0);

    // Interrupt handshake
    check_irq("irq_pending");
    ack(1'b0, "ack_to_zero");
    ack(1'b1, "ack_with_tick");
    ack(1'b0, "ack_after_tick");

    // Randomised mix
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: set_btn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        1: set_go(1'($urandom_range(0, 1)));
        2: ticks(int'($urandom_range(0, 5)));
        3: rd(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h10 + 8'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
        4: ack(1'($urandom_range(0, 1)), "rand_ack");
        default: begin
          score = 8'($urandom);
          rd(8'h12, 1'b0);
        end
      endcase
      check_irq("rand_irq");
    end

    // Reset mid-debounce: outputs clear at once and no press appears later
    set_btn(0, 1'b0);
    set_btn(1, 1'b0);
    set_go(1'b0);
    @(negedge clk);
    port_id = 8'h12;
    score   = 8'h5A;
    @(negedge clk);
    chk("pre_reset_in_port", in_port, 8'h5A);
    btn_raw[1] = 1'b1;
    m_irq = 1'b1;                         // ensure something is pending if irq build
    ticks(1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    btn_raw = 2'b00;
    #1;
    chk("mid_reset_in_port", in_port, 8'h00);
    chk("mid_reset_irq", {7'b0, interrupt}, 8'h00);
    m_btn = 2'b00; m_go = 1'b0; m_sticky = 4'b0; m_ticks = 0; m_irq = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check_irq("post_reset_irq");
    rd(8'h10, 1'b0);                      // 8'h00
    rd(8'h11, 1'b0);                      // 8'h00
    rd(8'h13, 1'b0);                      // 8'h00

    repeat (3) @(negedge clk);
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/picoblaze_in_port.md
Name: picoblaze_in_port

Overview:
- Read-side counterpart of the PicoBlaze output register.
- Drives KCPSM3 `in_port` so firmware can INPUT these values:
  - debounced push-buttons
  - game-over status
  - score
  - sticky event flags, read-cleared
- Optionally raises the KCPSM3 `interrupt` on new events, with an `interrupt_ack` handshake.
- Sits between the game logic (perdio, contador, posy change pulse) and the processor; replaces the constant `in_port` tie-off.

Parameters:
- BASE_PORT_ID, 8'h10, first of four consecutive port IDs decoded by this block.
- DEBOUNCE_CYCLES, 500000, stable-input cycles required before a button level is accepted (10 ms at 50 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- port_id  in  8  KCPSM3 port_id.
- read_strobe  in  1  KCPSM3 read_strobe.
- in_port  out  8  registered read data to KCPSM3.
- btn_raw  in  2  asynchronous push-button inputs, active-high.
- game_over  in  1  asynchronous level from collision logic.
- score  in  8  binary score, synchronous to clk.
- level_tick  in  1  single-cycle pulse, synchronous to clk, one per completed obstacle pass.
- interrupt  out  1  KCPSM3 interrupt request.
- interrupt_ack  in  1  KCPSM3 interrupt_ack pulse.

Behaviour:
- Clock and reset: one clock domain. reset asynchronously clears every register:
  - in_port = 8'h00, interrupt = 0
  - sync FFs, stable levels, debounce counters, sticky flags, tick counter all 0
- Synchronisers: btn_raw[1:0] and game_over each pass through 2 FFs; 2-cycle latency to the synced value.
- Debounce, per button i:
  - If synced != stable, cnt increments; otherwise cnt clears to 0.
  - When cnt == DEBOUNCE_CYCLES-1 and synced != stable: stable <= synced and cnt <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
  - The two buttons are fully independent.
- Event detection, each a one-cycle internal set pulse:
  - ev[0]: stable0 rising.
  - ev[1]: stable1 rising.
  - ev[2]: synced game_over rising.
  - ev[3]: level_tick.
- Register map (R = BASE_PORT_ID):
  - R+0 STATUS: {5'b0, go_sync, stable1, stable0}.
  - R+1 EVENTS: {4'b0, sticky[3:0]}. Sticky bit sets on its ev pulse; read-clears.
  - R+2 SCORE: score, pass-through.
  - R+3 TICKS: 8-bit count of level_tick pulses. Saturates at 8'hFF; read-clears.
  - Any other port_id returns 8'h00.
- Read timing:
  - in_port <= mux(port_id) on every clk edge, independent of read_strobe.
  - 1-cycle latency, which fits KCPSM3's 2-cycle INPUT (port_id stable both cycles).
- Read-clear:
  - Happens on the edge where read_strobe=1 and port_id matches R+1 or R+3.
  - Value returned is the pre-clear value.
  - Simultaneous event and clear on the same edge: the event survives (sticky bit ends 1; TICKS ends 1).
  - A read_strobe on R+0, R+2 or a non-matching ID has no side effects.
- Interrupt handshake, PICO_IN_IRQ_EN builds only:
  - irq_pend sets on any ev pulse and clears on interrupt_ack.
  - Ack and a new event on the same edge: irq_pend stays 1.
  - interrupt = irq_pend, registered.
  - Reading EVENTS does not clear irq_pend.
- Reset mid-debounce: counter discarded; stable returns to 0 and no press event is generated.

Optional Feature:
- Macro: PICO_IN_IRQ_EN.
- Defined: irq_pend logic as described; interrupt is driven.
- Undefined:
  - interrupt tied to 1'b0; interrupt_ack ignored; irq_pend not synthesised.
  - Firmware polls R+1 instead.
  - Register map and read-clear behaviour are identical in both builds.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=16, BASE_PORT_ID=8'h10.
1. Debounce:
   - btn_raw[0]=1 held 40 cycles, then read 8'h10 -> 8'h01 after sync + 16 cycles.
   - A 10-cycle pulse on btn_raw[1] -> STATUS bit1 stays 0; EVENTS stays 8'h00.
2. Sticky read-clear:
   - Press btn0 and btn1, assert game_over, then read 8'h11 -> 8'h07.
   - Second read of 8'h11 -> 8'h00.
3. Read-clear collision:
   - level_tick on the same edge as a read_strobe to 8'h11 -> that read returns the old value.
   - Next read returns 8'h08.
4. TICKS:
   - 300 level_tick pulses, then read 8'h13 -> 8'hFF, then 8'h00.
   - 3 more pulses -> 8'h03.
5. Map decode:
   - score=8'd42 -> read 8'h12 returns 8'h2A.
   - Read 8'h14 and 8'h00 -> 8'h00.
   - Read strobes to 8'h10/8'h12 leave EVENTS unchanged.
6. Interrupt and reset (PICO_IN_IRQ_EN defined):
   - btn0 press -> interrupt=1 within 1 cycle of ev[0].
   - interrupt_ack -> 0 next cycle; ack coincident with a level_tick -> stays 1.
   - reset asserted mid-debounce -> all outputs 0 immediately, no later press event.
   - Undefined build: interrupt constant 0 throughout.
